// File: rtl/pool_sequencer.sv
// rtl/pool_sequencer.sv - hasher pool job sequencer (latch, flush, run, report)
//
// Purpose: each committed job is loaded into the pool, which is then held in
// reset for a fixed flush period and released to run. While running, the
// block counts completed hash rounds. It reports a hit or exhaustion of the
// nonce space through the ready line.
//
// Ports:
//   g_clk, g_reset      clock; asynchronous active-high reset
//   job_load_in         pulse: new job configuration committed
//   abort_in            level: host halt request
//   pool_success_in     pool hit flag, with pool_nonce_in
//   pool_reset_out      holds the pool in reset (active-high)
//   job_latch_out       one-cycle pulse loading job registers into the pool
//   result_nonce_out    captured winning nonce
//   ready_out           result available (hit or exhaustion)
//   exhausted_out       nonce space searched without a hit
//   busy_out            job in progress (LATCH/FLUSH/RUN)
//   round_count_out     rounds completed for the current job
module pool_sequencer #(
    parameter int NONCE_WIDTH  = 31,
    parameter int FLUSH_CYCLES = 4,
    parameter int ROUND_CYCLES = 67
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic                   job_load_in,
    input  logic                   abort_in,
    input  logic                   pool_success_in,
    input  logic [NONCE_WIDTH-1:0] pool_nonce_in,
    output logic                   pool_reset_out,
    output logic                   job_latch_out,
    output logic [NONCE_WIDTH-1:0] result_nonce_out,
    output logic                   ready_out,
    output logic                   exhausted_out,
    output logic                   busy_out,
    output logic [NONCE_WIDTH-1:0] round_count_out
);

    localparam int CYC_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    // One extra value so a flush length of 1 still gets a 1-bit counter.
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CYC_W-1:0]       CYC_LAST  = CYC_W'(ROUND_CYCLES - 1);
    localparam logic [FL_W-1:0]        FL_LAST   = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [NONCE_WIDTH-1:0] ROUND_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_FLUSH,
        S_RUN,
        S_FOUND,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CYC_W-1:0]       cycle_q, cycle_d;
    logic [FL_W-1:0]        flush_q, flush_d;
    logic [NONCE_WIDTH-1:0] round_q, round_d;
    logic [NONCE_WIDTH-1:0] result_q, result_d;
    logic                   pool_reset_q, pool_reset_d;
    logic                   job_latch_q, job_latch_d;
    logic                   ready_q, ready_d;
    logic                   exhausted_q, exhausted_d;
    logic                   busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        flush_d  = flush_q;
        round_d  = round_q;
        result_d = result_q;

        if (abort_in) begin
            // Abort wins over everything; held in IDLE it also blocks new jobs.
            state_d = S_IDLE;
        end else if (job_load_in) begin
            // A job load from any state (including mid-run) restarts cleanly.
            state_d  = S_LATCH;
            round_d  = '0;
            result_d = '0;
            cycle_d  = '0;
            flush_d  = '0;
        end else begin
            case (state_q)
                S_LATCH: begin
                    state_d = S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_q == FL_LAST) begin
                        state_d = S_RUN;
                        cycle_d = '0;
                    end else begin
                        flush_d = flush_q + FL_W'(1);
                    end
                end
                S_RUN: begin
                    if (pool_success_in) begin
                        // A hit beats exhaustion on the same cycle.
                        result_d = pool_nonce_in;
                        state_d  = S_FOUND;
                    end else if (cycle_q == CYC_LAST) begin
                        cycle_d = '0;
                        if (round_q == ROUND_MAX) begin
                            // Count saturates at all-ones rather than wrapping.
                            state_d = S_DONE;
                        end else begin
                            round_d = round_q + NONCE_WIDTH'(1);
                        end
                    end else begin
                        cycle_d = cycle_q + CYC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // Outputs are registered and reflect the state being entered, so
        // they line up with the state for the whole cycle.
        pool_reset_d = (state_d != S_RUN);
        job_latch_d  = (state_d == S_LATCH);
        busy_d       = (state_d == S_LATCH) || (state_d == S_FLUSH) || (state_d == S_RUN);
        ready_d      = (state_d == S_FOUND) || (state_d == S_DONE);
        exhausted_d  = (state_d == S_DONE);
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q      <= S_IDLE;
            cycle_q      <= '0;
            flush_q      <= '0;
            round_q      <= '0;
            result_q     <= '0;
            pool_reset_q <= 1'b1;
            job_latch_q  <= 1'b0;
            ready_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            flush_q      <= flush_d;
            round_q      <= round_d;
            result_q     <= result_d;
            pool_reset_q <= pool_reset_d;
            job_latch_q  <= job_latch_d;
            ready_q      <= ready_d;
            exhausted_q  <= exhausted_d;
            busy_q       <= busy_d;
        end
    end

    assign pool_reset_out   = pool_reset_q;
    assign job_latch_out    = job_latch_q;
    assign result_nonce_out = result_q;
    assign ready_out        = ready_q;
    assign exhausted_out    = exhausted_q;
    assign busy_out         = busy_q;
    assign round_count_out  = round_q;

endmodule

// File: tb/tb_pool_sequencer.sv
// tb/tb_pool_sequencer.sv - directed self-checking bench for pool_sequencer
module tb_pool_sequencer;

    logic g_clk;
    logic g_reset;

    // Instance A: NONCE_WIDTH=31, FLUSH_CYCLES=4, ROUND_CYCLES=3
    logic        job_a, abort_a, succ_a;
    logic [30:0] nonce_a;
    logic        prst_a, latch_a, ready_a, exh_a, busy_a;
    logic [30:0] res_a, round_a;

    // Instance B: NONCE_WIDTH=4, FLUSH_CYCLES=4, ROUND_CYCLES=3
    logic        job_b, abort_b, succ_b;
    logic [3:0]  nonce_b;
    logic        prst_b, latch_b, ready_b, exh_b, busy_b;
    logic [3:0]  res_b, round_b;

    int n_checks = 0;
    int n_pass   = 0;

    pool_sequencer #(.NONCE_WIDTH(31), .FLUSH_CYCLES(4), .ROUND_CYCLES(3)) dut_a (
        .g_clk(g_clk), .g_reset(g_reset),
        .job_load_in(job_a), .abort_in(abort_a),
        .pool_success_in(succ_a), .pool_nonce_in(nonce_a),
        .pool_reset_out(prst_a), .job_latch_out(latch_a),
        .result_nonce_out(res_a), .ready_out(ready_a),
        .exhausted_out(exh_a), .busy_out(busy_a),
        .round_count_out(round_a)
    );

    pool_sequencer #(.NONCE_WIDTH(4), .FLUSH_CYCLES(4), .ROUND_CYCLES(3)) dut_b (
        .g_clk(g_clk), .g_reset(g_reset),
        .job_load_in(job_b), .abort_in(abort_b),
        .pool_success_in(succ_b), .pool_nonce_in(nonce_b),
        .pool_reset_out(prst_b), .job_latch_out(latch_b),
        .result_nonce_out(res_b), .ready_out(ready_b),
        .exhausted_out(exh_b), .busy_out(busy_b),
        .round_count_out(round_b)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    initial begin
        g_reset = 1'b1;
        job_a = 0; abort_a = 0; succ_a = 0; nonce_a = '0;
        job_b = 0; abort_b = 0; succ_b = 0; nonce_b = '0;
        ticks(2);
        check("rst_pool_reset", 32'(prst_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_latch", 32'(latch_a), 32'd0);
        check("rst_round", 32'(round_a), 32'd0);
        check("rst_result", 32'(res_a), 32'd0);
        g_reset = 1'b0;
        ticks(2);
        check("idle_pool_reset", 32'(prst_a), 32'd1);
        check("idle_busy", 32'(busy_a), 32'd0);

        // Job start: job sampled at edge 0
        job_a = 1;
        ticks(1);                                  // cycle 1 (LATCH)
        job_a = 0;
        check("start_latch_c1", 32'(latch_a), 32'd1);
        check("start_busy_c1", 32'(busy_a), 32'd1);
        check("start_prst_c1", 32'(prst_a), 32'd1);
        ticks(1);                                  // cycle 2 (FLUSH)
        check("start_latch_c2", 32'(latch_a), 32'd0);
        check("start_prst_c2", 32'(prst_a), 32'd1);
        check("start_busy_c2", 32'(busy_a), 32'd1);
        ticks(3);                                  // cycle 5 (last FLUSH)
        check("start_prst_c5", 32'(prst_a), 32'd1);
        ticks(1);                                  // cycle 6 (RUN)
        check("start_prst_c6", 32'(prst_a), 32'd0);
        check("start_busy_c6", 32'(busy_a), 32'd1);
        check("run_round0", 32'(round_a), 32'd0);

        // Hit after 3 full rounds
        ticks(9);                                  // cycle 15
        check("run_round3", 32'(round_a), 32'd3);
        check("run_ready0", 32'(ready_a), 32'd0);
        succ_a = 1; nonce_a = 31'h1234;
        ticks(1);
        succ_a = 0;
        check("hit_ready", 32'(ready_a), 32'd1);
        check("hit_nonce", 32'(res_a), 32'h1234);
        check("hit_round", 32'(round_a), 32'd3);
        check("hit_prst", 32'(prst_a), 32'd1);
        check("hit_busy", 32'(busy_a), 32'd0);
        check("hit_exh", 32'(exh_a), 32'd0);
        succ_a = 1; nonce_a = 31'h5555;            // stale hit ignored in FOUND
        ticks(2);
        succ_a = 0;
        check("found_hold_nonce", 32'(res_a), 32'h1234);
        check("found_hold_ready", 32'(ready_a), 32'd1);

        // job_load in FOUND: ready falls in LATCH cycle
        job_a = 1;
        ticks(1);
        job_a = 0;
        check("reload_latch", 32'(latch_a), 32'd1);
        check("reload_ready", 32'(ready_a), 32'd0);
        check("reload_round", 32'(round_a), 32'd0);
        check("reload_result", 32'(res_a), 32'd0);
        ticks(5);                                  // first RUN cycle
        check("reload_run_prst", 32'(prst_a), 32'd0);
        ticks(15);
        check("restart_round5", 32'(round_a), 32'd5);

        // Restart in RUN at round 5
        job_a = 1;
        ticks(1);                                  // LATCH
        job_a = 0;
        check("restart_latch", 32'(latch_a), 32'd1);
        check("restart_round0", 32'(round_a), 32'd0);
        check("restart_prst", 32'(prst_a), 32'd1);
        check("restart_busy", 32'(busy_a), 32'd1);
        ticks(4);                                  // last FLUSH cycle
        check("restart_flush_prst", 32'(prst_a), 32'd1);
        check("restart_flush_latch", 32'(latch_a), 32'd0);
        ticks(1);
        check("restart_run_prst", 32'(prst_a), 32'd0);

        // abort together with success in RUN
        abort_a = 1; succ_a = 1; nonce_a = 31'h7777;
        ticks(1);
        succ_a = 0;
        check("abort_hit_ready", 32'(ready_a), 32'd0);
        check("abort_hit_busy", 32'(busy_a), 32'd0);
        check("abort_hit_prst", 32'(prst_a), 32'd1);
        check("abort_hit_result", 32'(res_a), 32'd0);
        // abort held in IDLE blocks job_load
        job_a = 1;
        ticks(1);
        check("abort_idle_latch", 32'(latch_a), 32'd0);
        check("abort_idle_busy", 32'(busy_a), 32'd0);
        abort_a = 0;
        ticks(1);                                  // job now accepted
        check("post_abort_latch", 32'(latch_a), 32'd1);
        // abort together with job_load in LATCH
        abort_a = 1;
        ticks(1);
        abort_a = 0; job_a = 0;
        check("abort_job_busy", 32'(busy_a), 32'd0);
        check("abort_job_latch", 32'(latch_a), 32'd0);
        check("abort_job_prst", 32'(prst_a), 32'd1);

        // Asynchronous reset mid-RUN
        job_a = 1;
        ticks(1);
        job_a = 0;
        ticks(5);
        ticks(9);
        check("pre_rst_round", 32'(round_a), 32'd3);
        check("pre_rst_prst", 32'(prst_a), 32'd0);
        #3 g_reset = 1'b1;
        #1;
        check("async_rst_prst", 32'(prst_a), 32'd1);
        check("async_rst_busy", 32'(busy_a), 32'd0);
        check("async_rst_ready", 32'(ready_a), 32'd0);
        check("async_rst_round", 32'(round_a), 32'd0);
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        ticks(2);
        check("after_rst_busy", 32'(busy_a), 32'd0);
        check("after_rst_prst", 32'(prst_a), 32'd1);

        // Exhaustion on instance B: 48 RUN cycles
        job_b = 1;
        ticks(1);
        job_b = 0;
        ticks(5);                                  // first RUN cycle
        check("exh_run_prst", 32'(prst_b), 32'd0);
        ticks(47);                                 // last RUN cycle
        check("exh_last_busy", 32'(busy_b), 32'd1);
        check("exh_last_exh", 32'(exh_b), 32'd0);
        check("exh_last_round", 32'(round_b), 32'hF);
        ticks(1);
        check("exh_done_exh", 32'(exh_b), 32'd1);
        check("exh_done_ready", 32'(ready_b), 32'd1);
        check("exh_done_round", 32'(round_b), 32'hF);
        check("exh_done_prst", 32'(prst_b), 32'd1);
        check("exh_done_busy", 32'(busy_b), 32'd0);
        ticks(3);
        check("exh_hold_round", 32'(round_b), 32'hF);

        // Hit on the exhaustion cycle
        job_b = 1;
        ticks(1);
        job_b = 0;
        check("rejob_exh", 32'(exh_b), 32'd0);
        check("rejob_ready", 32'(ready_b), 32'd0);
        ticks(5);
        ticks(47);
        succ_b = 1; nonce_b = 4'hA;
        ticks(1);
        succ_b = 0;
        check("coll_ready", 32'(ready_b), 32'd1);
        check("coll_exh", 32'(exh_b), 32'd0);
        check("coll_nonce", 32'(res_b), 32'hA);
        check("coll_round", 32'(round_b), 32'hF);
        // abort from FOUND
        abort_b = 1;
        ticks(1);
        abort_b = 0;
        check("abort_found_ready", 32'(ready_b), 32'd0);
        check("abort_found_nonce", 32'(res_b), 32'hA);
        check("abort_found_round", 32'(round_b), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_sequencer.md
# pool_sequencer

Sequences the hasher pool for each job. When the external IO block commits a new job configuration, this block latches the job into the pool, holds the pool in reset for a fixed flush period, then runs it. While running it counts completed hash rounds and watches the pool's success flag. It reports a found nonce or search exhaustion to the host through the ready line, and sits between `external_io` and `shapool` inside `top`.

## Interface

Parameters:
- `NONCE_WIDTH`, default 31: width of the pool nonce and of the round counter (32 − POOL_SIZE_LOG2).
- `FLUSH_CYCLES`, default 4: cycles the pool is held in reset after a job latch (≥1).
- `ROUND_CYCLES`, default 67: clock cycles per pool hash round (≥2).

Ports:
- `g_clk` in, 1: global clock; the only clock.
- `g_reset` in, 1: reset, asynchronous, active-high.
- `job_load_in` in, 1: single-cycle pulse; a new job configuration has been committed.
- `abort_in` in, 1: level; host halt request.
- `pool_success_in` in, 1: pool reports a hit.
- `pool_nonce_in` in, NONCE_WIDTH: pool nonce, valid with `pool_success_in`.
- `pool_reset_out` out, 1: active-high; holds the pool in reset.
- `job_latch_out` out, 1: one-cycle pulse that loads job registers into the pool.
- `result_nonce_out` out, NONCE_WIDTH: captured winning nonce.
- `ready_out` out, 1: result available; drives ready_n_ts.
- `exhausted_out` out, 1: the full nonce space was searched without a hit.
- `busy_out` out, 1: a job is in progress.
- `round_count_out` out, NONCE_WIDTH: rounds completed for the current job.

## Operation

- States: IDLE, LATCH, FLUSH, RUN, FOUND, DONE. All outputs are registered.
- Reset values: state IDLE, `pool_reset_out`=1, all other outputs 0, internal counters 0.
- **IDLE:** `pool_reset_out`=1. On `job_load_in` → LATCH.
- **LATCH** (one cycle):
  - `job_latch_out`=1, `pool_reset_out`=1.
  - Clears `round_count_out`, `result_nonce_out`, `ready_out`, `exhausted_out`, the cycle counter and the flush counter.
  - → FLUSH.
- **FLUSH:** `pool_reset_out`=1 for exactly FLUSH_CYCLES cycles, then → RUN.
- **RUN:**
  - `pool_reset_out`=0.
  - The cycle counter runs 0..ROUND_CYCLES−1 and wraps to 0.
  - On each wrap, `round_count_out` increments.
- **Hit in RUN:** `pool_success_in`=1 → capture `pool_nonce_in` into `result_nonce_out`, then → FOUND.
- **Exhaustion in RUN:** the cycle counter wraps while `round_count_out` is all-ones → DONE. The count stays all-ones and does not wrap to 0.
- **FOUND:** `ready_out`=1, `pool_reset_out`=1, result held. Leaves only on `job_load_in` (→ LATCH) or `abort_in` (→ IDLE).
- **DONE:** `ready_out`=1, `exhausted_out`=1, `pool_reset_out`=1. Exits are the same as FOUND.
- `busy_out`=1 in LATCH, FLUSH and RUN only.
- Priority when events coincide: `abort_in` > `job_load_in` > `pool_success_in` > exhaustion.
  - `abort_in` in any non-IDLE state → IDLE next cycle. `ready_out` and `exhausted_out` clear; `result_nonce_out` and `round_count_out` hold.
  - `abort_in` held in IDLE blocks `job_load_in`.
  - `job_load_in` in LATCH, FLUSH or RUN restarts the job (→ LATCH).
- `pool_success_in` outside RUN is ignored (stale result from the previous job or the flush period).
- Arithmetic: all counters are unsigned. The round counter is NONCE_WIDTH bits; the cycle counter is clog2(ROUND_CYCLES) bits.

## Timing

- `job_load_in` sampled high at edge t:
  - LATCH during cycle t+1 (`job_latch_out` high that cycle only).
  - FLUSH during cycles t+2 .. t+1+FLUSH_CYCLES.
  - RUN from cycle t+2+FLUSH_CYCLES; `pool_reset_out` falls at that edge.
- `pool_success_in` sampled at edge e in RUN: `ready_out`=1, `pool_reset_out`=1 and `result_nonce_out` valid from e+1. Single-cycle latency.
- Exhaustion: with no hit, RUN lasts exactly 2^NONCE_WIDTH × ROUND_CYCLES cycles before DONE.
- `g_reset` asserted mid-operation: outputs take reset values immediately (asynchronous), without waiting for an edge. Deassertion is synchronous to `g_clk`.

## Test plan

- **Reset mid-RUN:** assert `g_reset` between edges → `pool_reset_out`=1 and `ready_out`, `busy_out`, `round_count_out` all 0 before the next edge; state IDLE after release.
- **Job start (FLUSH_CYCLES=4):** `job_load_in` at edge 0 → `job_latch_out` high in cycle 1 only; `pool_reset_out` high through cycle 5 and 0 from cycle 6; `busy_out`=1 from cycle 1.
- **Hit (ROUND_CYCLES=3):** `pool_success_in` with nonce 0x1234 after 3 full rounds → next cycle `ready_out`=1, `result_nonce_out`=0x1234, `round_count_out`=3, `pool_reset_out`=1, `busy_out`=0.
- **Exhaustion (NONCE_WIDTH=4, ROUND_CYCLES=3), no hit:** → DONE after exactly 48 RUN cycles; `exhausted_out`=1, `ready_out`=1, `round_count_out`=0xF.
- **Collisions:**
  - `abort_in` together with `pool_success_in` → IDLE, `ready_out`=0.
  - `pool_success_in` on the exhaustion cycle → FOUND, `exhausted_out`=0.
  - `abort_in` together with `job_load_in` → IDLE.
- **Restart:** `job_load_in` in RUN at round 5 → `job_latch_out` pulse, `round_count_out`=0, full FLUSH repeated. Then `job_load_in` in FOUND → `ready_out` falls in the LATCH cycle.
